// File: rtl/mux_arbiter_5_pkg.sv
// Shared definitions for the 5-way round-robin path arbiter:
// requester count, mux select encoding and FSM state type.
package mux_arbiter_5_pkg;

  localparam int NUM_REQ = 5;

  localparam logic [2:0] SEL_IN1 = 3'b000;
  localparam logic [2:0] SEL_IN2 = 3'b001;
  localparam logic [2:0] SEL_IN3 = 3'b010;
  localparam logic [2:0] SEL_IN4 = 3'b011;
  localparam logic [2:0] SEL_IN5 = 3'b100;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  // Successor in round-robin order; index 4 wraps back to 0.
  function automatic logic [2:0] next_idx(input logic [2:0] i);
    return (i == SEL_IN5) ? SEL_IN1 : i + 3'd1;
  endfunction

endpackage

// File: rtl/rr_pick5.sv
// Combinational round-robin search: first set bit of (req & ~excl),
// scanning from start upward and wrapping 4 -> 0.
module rr_pick5
  import mux_arbiter_5_pkg::*;
(
  input  logic [4:0] req,
  input  logic [2:0] start,
  input  logic [4:0] excl,
  output logic       found,
  output logic [2:0] idx
);

  logic [4:0] cand;
  logic [2:0] pos;

  always_comb begin
    found = 1'b0;
    idx   = start;
    cand  = req & ~excl;
    pos   = start;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && cand[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
      pos = next_idx(pos);
    end
  end

endmodule

// File: rtl/mux_arbiter_5.sv
// Round-robin owner arbiter for a shared 32-bit path feeding a 5-to-1 mux,
// with a hold limit that forces release only while someone else is waiting.
//
//   state | meaning
//   IDLE  | no owner; grant = 0, sel keeps its last code
//   OWN   | requester 'owner' holds the path; hold_cnt counts owned cycles
module mux_arbiter_5
  import mux_arbiter_5_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [4:0] req,
  output logic [4:0] grant,
  output logic [2:0] sel,
  output logic       busy,
  output logic       expire
);

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t     state, state_nx;
  logic [2:0] owner, owner_nx;
  logic [2:0] ptr, ptr_nx;
  logic [3:0] hold_cnt, hold_nx;
  logic [4:0] grant_nx;
  logic [2:0] sel_nx;
  logic       busy_nx;
  logic       expire_nx;

  logic [4:0] owner_oh;
  logic       others;
  logic       rel;
  logic [2:0] srch_start;
  logic [4:0] srch_excl;
  logic       found;
  logic [2:0] win;

  // While owning, the search always starts just past the owner and skips it,
  // which is exactly the post-release pointer.
  always_comb begin
    owner_oh   = 5'b00001 << owner;
    others     = |(req & ~owner_oh);
    srch_start = (state == OWN) ? next_idx(owner) : ptr;
    srch_excl  = (state == OWN) ? owner_oh : 5'b00000;
  end

  rr_pick5 u_pick (
    .req   (req),
    .start (srch_start),
    .excl  (srch_excl),
    .found (found),
    .idx   (win)
  );

  always_comb begin
    state_nx  = state;
    owner_nx  = owner;
    ptr_nx    = ptr;
    hold_nx   = hold_cnt;
    grant_nx  = grant;
    sel_nx    = sel;
    expire_nx = 1'b0;
    rel       = 1'b0;
    case (state)
      IDLE: begin
        grant_nx = 5'b00000;
        if (found) begin
          state_nx = OWN;
          owner_nx = win;
          hold_nx  = 4'd0;
          grant_nx = 5'b00001 << win;
          sel_nx   = win;
        end
      end
      OWN: begin
        if (!req[owner]) begin
          rel = 1'b1;
        end else if (hold_cnt == HOLD_LAST && others) begin
          rel       = 1'b1;
          expire_nx = 1'b1;
        end
        if (rel) begin
          ptr_nx = next_idx(owner);
          if (found) begin
            owner_nx = win;
            hold_nx  = 4'd0;
            grant_nx = 5'b00001 << win;
            sel_nx   = win;
          end else begin
            state_nx = IDLE;
            grant_nx = 5'b00000;
          end
        end else if (hold_cnt != HOLD_LAST) begin
          hold_nx = hold_cnt + 4'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        grant_nx = 5'b00000;
      end
    endcase
    busy_nx = (grant_nx != 5'b00000);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= IDLE;
      owner    <= SEL_IN1;
      ptr      <= SEL_IN1;
      hold_cnt <= 4'd0;
      grant    <= 5'b00000;
      sel      <= SEL_IN1;
      busy     <= 1'b0;
      expire   <= 1'b0;
    end else begin
      state    <= state_nx;
      owner    <= owner_nx;
      ptr      <= ptr_nx;
      hold_cnt <= hold_nx;
      grant    <= grant_nx;
      sel      <= sel_nx;
      busy     <= busy_nx;
      expire   <= expire_nx;
    end
  end

endmodule
